// File: rtl/apu_pkg.sv
// Shared definitions for the APU note path: FSM encoding, command entry layout
// and field widths also used by the oscillator.
package apu_pkg;

    localparam int DIVIDER_W  = 12;
    localparam int DURATION_W = 8;
    localparam int TICK_CNT_W = 9;
    localparam int NOTE_CMD_W = 21;

    // Queue entry layout: {rest, duration[7:0], divider[11:0]}
    localparam int DIV_LSB  = 0;
    localparam int DUR_LSB  = DIV_LSB + DIVIDER_W;
    localparam int REST_BIT = DUR_LSB + DURATION_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_PLAY = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    typedef struct packed {
        logic                  rest;
        logic [DURATION_W-1:0] duration;
        logic [DIVIDER_W-1:0]  divider;
    } note_cmd_t;

    // A duration field of 0 stands for the longest note, 256 ticks.
    function automatic logic [TICK_CNT_W-1:0] note_ticks(input logic [DURATION_W-1:0] dur);
        return (dur == '0) ? TICK_CNT_W'(256) : {1'b0, dur};
    endfunction

endpackage

// File: rtl/apu_note_sequencer_if.sv
// Command bus into the note sequencer.
// A command transfers on a rising clk edge where cmd_valid && cmd_ready; the
// master holds the command fields stable while cmd_valid is high and not yet accepted.
interface apu_note_sequencer_if;
    import apu_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [DIVIDER_W-1:0]  cmd_divider;
    logic [DURATION_W-1:0] cmd_duration;
    logic                  cmd_rest;

    modport master (
        output cmd_valid,
        output cmd_divider,
        output cmd_duration,
        output cmd_rest,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_divider,
        input  cmd_duration,
        input  cmd_rest,
        output cmd_ready
    );

endinterface

// File: rtl/apu_cmd_fifo.sv
// Synchronous FIFO for queued note commands with flush and async active-low reset.
// DEPTH must be a power of two, at least 2.
module apu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/apu_note_sequencer.sv
// Plays queued note commands back-to-back, driving the sine oscillator's divider,
// phase-restart reset and output gate.
module apu_note_sequencer
    import apu_pkg::*;
#(
    parameter int TICK_DIV   = 50000,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_TICKS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    apu_note_sequencer_if.slave  cmd,
    input  logic                 stop,
    output logic [DIVIDER_W-1:0] osc_divider,
    output logic                 osc_rst_n,
    output logic                 gate,
    output logic                 busy,
    output logic                 note_done,
    output logic [1:0]           o_dbg_state
);

    localparam int                PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [1:0]            r_state;
    logic [PRE_W-1:0]      r_prescale;
    logic [TICK_CNT_W-1:0] r_remaining;
    logic                  r_rest;
    logic [DIVIDER_W-1:0]  r_divider;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [NOTE_CMD_W-1:0] w_push_data;
    logic [NOTE_CMD_W-1:0] w_head_raw;
    note_cmd_t             w_head;
    logic                  w_tick;
    logic                  w_last_tick;
    logic                  w_note_end;

    assign cmd.cmd_ready = !w_full && !stop;
    assign w_push        = cmd.cmd_valid && cmd.cmd_ready;
    assign w_pop         = (r_state == ST_LOAD) && !stop;
    assign w_push_data   = {cmd.cmd_rest, cmd.cmd_duration, cmd.cmd_divider};
    assign w_head        = note_cmd_t'(w_head_raw);

    apu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (NOTE_CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (stop),
        .i_data  (w_push_data),
        .o_data  (w_head_raw),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // The same prescaler/tick counter pair times both the note and the gap.
    assign w_tick      = (r_prescale == PRE_LAST);
    assign w_last_tick = w_tick && (r_remaining == TICK_CNT_W'(1));
    assign w_note_end  = (r_state == ST_PLAY) && w_last_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_prescale  <= '0;
            r_remaining <= '0;
            r_rest      <= 1'b0;
            r_divider   <= '0;
        end else if (stop) begin
            r_state     <= ST_IDLE;
            r_prescale  <= '0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (!w_head.rest) r_divider <= w_head.divider;
                    r_rest      <= w_head.rest;
                    r_remaining <= note_ticks(w_head.duration);
                    r_prescale  <= '0;
                    r_state     <= ST_PLAY;
                end
                default: begin
                    r_prescale <= w_tick ? '0 : r_prescale + PRE_W'(1);
                    if (w_tick) r_remaining <= r_remaining - TICK_CNT_W'(1);
                    if (w_last_tick) begin
                        if ((r_state == ST_PLAY) && (GAP_TICKS > 0)) begin
                            r_state     <= ST_GAP;
                            r_remaining <= TICK_CNT_W'(GAP_TICKS);
                        end else begin
                            r_state <= w_empty ? ST_IDLE : ST_LOAD;
                        end
                    end
                end
            endcase
        end
    end

    // Rest notes hold the oscillator in reset so it stays silent at phase 0.
    assign osc_divider = r_divider;
    assign gate        = (r_state == ST_PLAY) && !r_rest;
    assign osc_rst_n   = (r_state == ST_PLAY) && !r_rest;
    assign note_done   = w_note_end && !stop;
    assign busy        = (r_state != ST_IDLE) || !w_empty;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apu_note_sequencer.sv
// Directed bench for apu_note_sequencer with TICK_DIV=4, FIFO_DEPTH=4, GAP_TICKS=1.
module tb_apu_note_sequencer;
    import apu_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 stop = 1'b0;
    logic [DIVIDER_W-1:0] osc_divider;
    logic                 osc_rst_n;
    logic                 gate;
    logic                 busy;
    logic                 note_done;
    logic [1:0]           dbg_state;

    int checks = 0;
    int failures = 0;
    logic [11:0] exp_q[$];
    logic [11:0] obs_q[$];

    apu_note_sequencer_if cmd_if();

    apu_note_sequencer #(
        .TICK_DIV   (4),
        .FIFO_DEPTH (4),
        .GAP_TICKS  (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd         (cmd_if),
        .stop        (stop),
        .osc_divider (osc_divider),
        .osc_rst_n   (osc_rst_n),
        .gate        (gate),
        .busy        (busy),
        .note_done   (note_done),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (note_done) obs_q.push_back(osc_divider);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input bit valid, input int div, input int dur, input bit rest);
        cmd_if.cmd_valid    = valid;
        cmd_if.cmd_divider  = 12'(div);
        cmd_if.cmd_duration = 8'(dur);
        cmd_if.cmd_rest     = rest;
    endtask

    task automatic test_reset();
        set_cmd(1'b0, 0, 0, 1'b0);
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();
        checks++; if (gate !== 1'b0) begin failures++; $display("FAIL reset_gate: got %0b expected 0", gate); end
        checks++; if (osc_rst_n !== 1'b0) begin failures++; $display("FAIL reset_osc_rst_n: got %0b expected 0", osc_rst_n); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (cmd_if.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready: got %0b expected 1", cmd_if.cmd_ready); end
        checks++; if (osc_divider !== 12'd0) begin failures++; $display("FAIL reset_osc_divider: got %0d expected 0", osc_divider); end
        checks++; if (note_done !== 1'b0) begin failures++; $display("FAIL reset_note_done: got %0b expected 0", note_done); end
        checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_single_note();
        int first_gate = -1;
        int gate_cnt = 0;
        int done_cyc = -1;
        int idle_cyc = -1;
        logic [1:0] st2 = '0;
        logic [1:0] st15 = '0;
        logic rst3 = 1'b0;
        set_cmd(1'b1, 100, 3, 1'b0);
        step();
        set_cmd(1'b0, 0, 0, 1'b0);
        for (int c = 1; c <= 30; c++) begin
            if (c == 2) st2 = dbg_state;
            if (c == 3) rst3 = osc_rst_n;
            if (c == 15) st15 = dbg_state;
            if (gate) begin
                gate_cnt++;
                if (first_gate < 0) first_gate = c;
            end
            if (note_done && done_cyc < 0) done_cyc = c;
            if (!busy && idle_cyc < 0) idle_cyc = c;
            step();
        end
        checks++; if (st2 !== ST_LOAD) begin failures++; $display("FAIL single_load_cycle2: got %0d expected %0d", st2, ST_LOAD); end
        checks++; if (first_gate != 3) begin failures++; $display("FAIL single_first_gate: got %0d expected 3", first_gate); end
        checks++; if (gate_cnt != 12) begin failures++; $display("FAIL single_gate_len: got %0d expected 12", gate_cnt); end
        checks++; if (rst3 !== 1'b1) begin failures++; $display("FAIL single_osc_rst_n: got %0b expected 1", rst3); end
        checks++; if (done_cyc != 14) begin failures++; $display("FAIL single_note_done_cycle: got %0d expected 14", done_cyc); end
        checks++; if (st15 !== ST_GAP) begin failures++; $display("FAIL single_gap_cycle15: got %0d expected %0d", st15, ST_GAP); end
        checks++; if (idle_cyc != 19) begin failures++; $display("FAIL single_idle_cycle: got %0d expected 19", idle_cyc); end
        checks++; if (osc_divider !== 12'd100) begin failures++; $display("FAIL single_divider: got %0d expected 100", osc_divider); end
    endtask

    task automatic test_queue_full();
        int n_acc = 0;
        int guard = 0;
        int wait_cnt = 0;
        bit acc;
        obs_q.delete();
        exp_q = '{12'd10, 12'd20, 12'd30, 12'd40, 12'd50};
        while (n_acc < 5 && guard < 50) begin
            set_cmd(1'b1, 10 * (n_acc + 1), 1, 1'b0);
            acc = cmd_if.cmd_ready;
            step();
            guard++;
            if (acc) n_acc++;
        end
        checks++; if (n_acc != 5) begin failures++; $display("FAIL full_accepted: got %0d expected 5", n_acc); end
        checks++; if (guard != 5) begin failures++; $display("FAIL full_push_cycles: got %0d expected 5", guard); end
        // Queue now holds 4 entries: a held command must stall.
        set_cmd(1'b1, 99, 1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (cmd_if.cmd_ready !== 1'b0) begin failures++; $display("FAIL full_ready_low[%0d]: got %0b expected 0", i, cmd_if.cmd_ready); end
            step();
        end
        set_cmd(1'b0, 0, 0, 1'b0);
        while (busy && wait_cnt < 200) begin
            step();
            wait_cnt++;
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_drain_timeout: busy got %0b expected 0", busy); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL full_note_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL full_order[%0d]: got %0d expected %0d", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_rest_note();
        int silent = 0;
        int sound = 0;
        int done_cnt = 0;
        int last_done = -1;
        int idle_cyc = -1;
        int div_bad = 0;
        set_cmd(1'b1, 100, 1, 1'b0);
        step();
        set_cmd(1'b1, 7, 2, 1'b1);
        step();
        set_cmd(1'b0, 0, 0, 1'b0);
        for (int c = 2; c <= 30; c++) begin
            if (dbg_state == ST_PLAY && !gate && !osc_rst_n) silent++;
            if (dbg_state == ST_PLAY && gate) sound++;
            if (c >= 3 && osc_divider != 12'd100) div_bad++;
            if (note_done) begin
                done_cnt++;
                last_done = c;
            end
            if (!busy && idle_cyc < 0) idle_cyc = c;
            step();
        end
        checks++; if (silent != 8) begin failures++; $display("FAIL rest_silent_len: got %0d expected 8", silent); end
        checks++; if (sound != 4) begin failures++; $display("FAIL rest_sound_len: got %0d expected 4", sound); end
        checks++; if (div_bad != 0) begin failures++; $display("FAIL rest_divider_held: got %0d bad cycles expected 0", div_bad); end
        checks++; if (done_cnt != 2) begin failures++; $display("FAIL rest_note_done_count: got %0d expected 2", done_cnt); end
        checks++; if (last_done != 19) begin failures++; $display("FAIL rest_note_done_cycle: got %0d expected 19", last_done); end
        checks++; if (idle_cyc != 24) begin failures++; $display("FAIL rest_idle_cycle: got %0d expected 24", idle_cyc); end
    endtask

    task automatic test_duration_zero();
        int first_gate = -1;
        int gate_cnt = 0;
        int idle_cyc = -1;
        set_cmd(1'b1, 5, 0, 1'b0);
        step();
        set_cmd(1'b0, 0, 0, 1'b0);
        for (int c = 1; c <= 1040; c++) begin
            if (gate) begin
                gate_cnt++;
                if (first_gate < 0) first_gate = c;
            end
            if (!busy && idle_cyc < 0) idle_cyc = c;
            step();
        end
        checks++; if (gate_cnt != 1024) begin failures++; $display("FAIL dur0_gate_len: got %0d expected 1024", gate_cnt); end
        checks++; if (first_gate != 3) begin failures++; $display("FAIL dur0_first_gate: got %0d expected 3", first_gate); end
        checks++; if (idle_cyc != 1031) begin failures++; $display("FAIL dur0_idle_cycle: got %0d expected 1031", idle_cyc); end
        checks++; if (osc_divider !== 12'd5) begin failures++; $display("FAIL dur0_divider: got %0d expected 5", osc_divider); end
    endtask

    task automatic test_stop();
        int busy_cnt = 0;
        int done_cnt = 0;
        obs_q.delete();
        set_cmd(1'b1, 11, 2, 1'b0);
        step();
        set_cmd(1'b1, 22, 2, 1'b0);
        step();
        set_cmd(1'b1, 33, 2, 1'b0);
        step();
        set_cmd(1'b0, 0, 0, 1'b0);
        repeat (7) step();
        // Cycle 10: last PLAY cycle of the first note, two commands still queued.
        checks++; if (gate !== 1'b1) begin failures++; $display("FAIL stop_pre_gate: got %0b expected 1", gate); end
        stop = 1'b1;
        set_cmd(1'b1, 77, 1, 1'b0);
        #1;
        checks++; if (note_done !== 1'b0) begin failures++; $display("FAIL stop_note_done_masked: got %0b expected 0", note_done); end
        checks++; if (cmd_if.cmd_ready !== 1'b0) begin failures++; $display("FAIL stop_ready: got %0b expected 0", cmd_if.cmd_ready); end
        step();
        stop = 1'b0;
        set_cmd(1'b0, 0, 0, 1'b0);
        checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL stop_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        checks++; if (gate !== 1'b0) begin failures++; $display("FAIL stop_gate: got %0b expected 0", gate); end
        checks++; if (osc_rst_n !== 1'b0) begin failures++; $display("FAIL stop_osc_rst_n: got %0b expected 0", osc_rst_n); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stop_busy: got %0b expected 0", busy); end
        checks++; if (osc_divider !== 12'd11) begin failures++; $display("FAIL stop_divider_hold: got %0d expected 11", osc_divider); end
        for (int c = 0; c < 20; c++) begin
            if (busy) busy_cnt++;
            if (note_done) done_cnt++;
            step();
        end
        checks++; if (busy_cnt != 0) begin failures++; $display("FAIL stop_stays_idle: got %0d busy cycles expected 0", busy_cnt); end
        checks++; if (done_cnt != 0 || obs_q.size() != 0) begin failures++; $display("FAIL stop_no_note_done: got %0d pulses expected 0", obs_q.size()); end
    endtask

    task automatic test_async_reset();
        set_cmd(1'b1, 200, 3, 1'b0);
        step();
        set_cmd(1'b1, 201, 3, 1'b0);
        step();
        set_cmd(1'b0, 0, 0, 1'b0);
        repeat (3) step();
        checks++; if (gate !== 1'b1) begin failures++; $display("FAIL areset_pre_gate: got %0b expected 1", gate); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (gate !== 1'b0) begin failures++; $display("FAIL areset_gate: got %0b expected 0", gate); end
        checks++; if (osc_rst_n !== 1'b0) begin failures++; $display("FAIL areset_osc_rst_n: got %0b expected 0", osc_rst_n); end
        checks++; if (osc_divider !== 12'd0) begin failures++; $display("FAIL areset_divider: got %0d expected 0", osc_divider); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL areset_busy: got %0b expected 0", busy); end
        checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL areset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        set_cmd(1'b1, 9, 1, 1'b0);
        repeat (2) step();
        set_cmd(1'b0, 0, 0, 1'b0);
        rst_n = 1'b1;
        repeat (3) step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL areset_release_busy: got %0b expected 0", busy); end
        checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL areset_release_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        checks++; if (cmd_if.cmd_ready !== 1'b1) begin failures++; $display("FAIL areset_release_ready: got %0b expected 1", cmd_if.cmd_ready); end
    endtask

    initial begin
        test_reset();
        test_single_note();
        test_queue_full();
        test_rest_note();
        test_duration_zero();
        test_stop();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
